// File: rtl/associate_pkg.sv
// Shared types, FSM states and fixed-point helpers for associate_unit.
// ASSOCIATE_SATURATE_EN selects saturating instead of wrapping 16-bit results.
package associate_pkg;

  typedef logic [7:0]         arg_t;
  typedef logic signed [15:0] fix_t;

  typedef enum logic [2:0] {
    StArg,
    StFwd,
    StRes,
    StErr,
    StBwd,
    StFbk
  } state_t;

  localparam int unsigned AccW = 20;

  // Reduce a widened signed value back to Q8.8.
  function automatic fix_t sat16(input logic signed [23:0] v);
`ifdef ASSOCIATE_SATURATE_EN
    if (v > 24'sd32767) begin
      return 16'sh7fff;
    end else if (v < -24'sd32768) begin
      return 16'sh8000;
    end else begin
      return 16'(v);
    end
`else
    return 16'(v);
`endif
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hb400) : (s >> 1);
  endfunction

  // Weight idx takes the LFSR state after idx+1 steps from the seed.
  function automatic fix_t seed_weight(input logic [15:0] seed, input int unsigned idx);
    logic [15:0] s;
    s = seed;
    for (int unsigned k = 0; k <= idx; k++) begin
      s = lfsr_step(s);
    end
    return s;
  endfunction

endpackage

// File: rtl/associate_mul.sv
// Signed Q8.8 multiply with an arithmetic >>>8 rescale.
module associate_mul (
  input  logic signed [15:0] i_a,
  input  logic signed [15:0] i_b,
  output logic signed [23:0] o_p
);

  logic signed [31:0] w_full;

  assign w_full = 32'(i_a) * 32'(i_b);
  assign o_p    = 24'(w_full >>> 8);

endmodule

// File: rtl/associate_unit.sv
// Trainable single-neuron linear associator with valid/ready streams.
// ASSOCIATE_SATURATE_EN: saturate result and weight/bias updates instead of wrapping.
module associate_unit
  import associate_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned RATE = 0,
  parameter int unsigned SEED = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_train,
  input  logic               i_arg_valid,
  output logic               o_arg_ready,
  input  logic [N-1:0][7:0]  i_arg_data,
  output logic               o_res_valid,
  input  logic               i_res_ready,
  output logic [15:0]        o_res_data,
  input  logic               i_err_valid,
  output logic               o_err_ready,
  input  logic [15:0]        i_err_data,
  output logic               o_fbk_valid,
  input  logic               i_fbk_ready,
  output logic [N-1:0][15:0] o_fbk_data
);

  localparam int unsigned     IdxW    = $clog2(N + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
  localparam logic [IdxW-1:0] BiasIdx = IdxW'(N);

  state_t                  r_state, w_state_d;
  logic                    r_live;
  logic                    r_train;
  logic [IdxW-1:0]         r_idx;
  logic [N-1:0][7:0]       r_arg;
  fix_t                    r_err;
  fix_t                    r_bias;
  fix_t                    r_weight [N];
  logic signed [AccW-1:0]  r_acc;
  logic [15:0]             r_res;
  logic [N-1:0][15:0]      r_fbk;

  fix_t                    w_sel_weight, w_arg_ext, w_mul_b;
  fix_t                    w_delta, w_rated_delta, w_rated_err;
  fix_t                    w_weight_next, w_bias_next;
  arg_t                    w_sel_arg;
  logic signed [23:0]      w_prod_a, w_prod_b;
  logic signed [AccW-1:0]  w_acc_next;

  always_comb begin
    w_sel_weight = '0;
    w_sel_arg    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_idx == IdxW'(i)) begin
        w_sel_weight = r_weight[i];
        w_sel_arg    = r_arg[i];
      end
    end
  end

  // Unit A: weight*arg in the forward pass, weight*err for feedback.
  assign w_arg_ext = {8'h00, w_sel_arg};
  assign w_mul_b   = (r_state == StBwd) ? r_err : w_arg_ext;

  associate_mul u_mul_a (
    .i_a (w_sel_weight),
    .i_b (w_mul_b),
    .o_p (w_prod_a)
  );

  associate_mul u_mul_delta (
    .i_a (r_err),
    .i_b (w_arg_ext),
    .o_p (w_prod_b)
  );

  assign w_acc_next    = r_acc + AccW'(w_prod_a);
  assign w_delta       = 16'(w_prod_b);
  assign w_rated_delta = w_delta >>> RATE;
  assign w_rated_err   = r_err >>> RATE;
  assign w_weight_next = sat16(24'(w_sel_weight) + 24'(w_rated_delta));
  assign w_bias_next   = sat16(24'(r_bias) + 24'(w_rated_err));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StArg;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StArg:   if (i_arg_valid && r_live) w_state_d = StFwd;
      StFwd:   if (r_idx == LastIdx) w_state_d = StRes;
      StRes:   if (i_res_ready) w_state_d = r_train ? StErr : StArg;
      StErr:   if (i_err_valid) w_state_d = StBwd;
      StBwd:   if (r_idx == BiasIdx) w_state_d = StFbk;
      StFbk:   if (i_fbk_ready) w_state_d = StArg;
      default: w_state_d = StArg;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_train <= 1'b0;
      r_idx   <= '0;
      r_arg   <= '0;
      r_err   <= '0;
      r_bias  <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_fbk   <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_weight[i] <= (SEED == 0) ? '0 : seed_weight(16'(SEED), i);
      end
    end else begin
      case (r_state)
        StArg: begin
          if (o_arg_ready && i_arg_valid) begin
            r_arg   <= i_arg_data;
            r_train <= i_train;
            r_idx   <= '0;
            r_acc   <= AccW'(r_bias);
          end
        end
        StFwd: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + IdxW'(1);
          if (r_idx == LastIdx) r_res <= sat16(24'(w_acc_next));
        end
        StErr: begin
          if (i_err_valid) begin
            r_err <= i_err_data;
            r_idx <= '0;
          end
        end
        StBwd: begin
          r_idx <= r_idx + IdxW'(1);
          if (r_idx == BiasIdx) r_bias <= w_bias_next;
          // Feedback uses the weight before this cycle's update.
          for (int unsigned i = 0; i < N; i++) begin
            if (r_idx == IdxW'(i)) begin
              r_weight[i] <= w_weight_next;
              r_fbk[i]    <= 16'(w_prod_a);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_arg_ready = (r_state == StArg) && r_live;
  assign o_res_valid = (r_state == StRes);
  assign o_err_ready = (r_state == StErr);
  assign o_fbk_valid = (r_state == StFbk);
  assign o_res_data  = r_res;
  assign o_fbk_data  = r_fbk;

endmodule

// File: tb/tb_associate_unit.sv
// Scoreboard bench for associate_unit (N=2, RATE=0, SEED=0).
module tb_associate_unit;

  localparam int Rate = 0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             train, arg_valid, arg_ready;
  logic [1:0][7:0]  arg_data;
  logic             res_valid, res_ready;
  logic [15:0]      res_data;
  logic             err_valid, err_ready;
  logic [15:0]      err_data;
  logic             fbk_valid, fbk_ready;
  logic [1:0][15:0] fbk_data;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] res_q[$];
  logic [31:0] fbk_q[$];
  logic [15:0] last_res;
  int          m_w[2];
  int          m_b;
  logic [3:0][15:0] pats;

  always #5 clk = ~clk;

  associate_unit #(.N(2), .RATE(0), .SEED(0)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_train     (train),
    .i_arg_valid (arg_valid),
    .o_arg_ready (arg_ready),
    .i_arg_data  (arg_data),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_data  (res_data),
    .i_err_valid (err_valid),
    .o_err_ready (err_ready),
    .i_err_data  (err_data),
    .o_fbk_valid (fbk_valid),
    .i_fbk_ready (fbk_ready),
    .o_fbk_data  (fbk_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic int wrap16(input int v);
    logic signed [15:0] t;
`ifdef ASSOCIATE_SATURATE_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int m_fwd(input logic [15:0] a);
    int s;
    s = m_b;
    for (int i = 0; i < 2; i++) s += (m_w[i] * int'(a[8*i +: 8])) >>> 8;
    return wrap16(s);
  endfunction

  function automatic logic [31:0] m_bwd(input logic [15:0] a, input int er);
    logic [31:0] f;
    for (int i = 0; i < 2; i++) begin
      f[16*i +: 16] = 16'((er * m_w[i]) >>> 8);
      m_w[i] = wrap16(m_w[i] + (((er * int'(a[8*i +: 8])) >>> 8) >>> Rate));
    end
    m_b = wrap16(m_b + (er >>> Rate));
    return f;
  endfunction

  // Monitor: compare every completed output handshake with the scoreboard.
  initial begin
    logic [15:0] er;
    logic [31:0] ef;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL res_unexpected: got %h expected none", res_data);
        end else begin
          er = res_q.pop_front();
          check("res", {16'h0, res_data}, {16'h0, er});
        end
      end
      if (rst_n && fbk_valid && fbk_ready) begin
        if (fbk_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL fbk_unexpected: got %h expected none", fbk_data);
        end else begin
          ef = fbk_q.pop_front();
          check("fbk", fbk_data, ef);
        end
      end
    end
  end

  task automatic send_arg(input logic [15:0] a, input logic t);
    bit hs = 0;
    arg_data = a; train = t; arg_valid = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = arg_ready;
      @(posedge clk); #1;
    end
    arg_valid = 1'b0;
    check("arg_handshake", {31'h0, hs}, 1);
  endtask

  task automatic wait_res();
    bit hs = 0;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk);
      if (res_valid && res_ready) begin hs = 1; last_res = res_data; end
      @(posedge clk); #1;
    end
    check("res_handshake", {31'h0, hs}, 1);
  endtask

  task automatic send_err(input logic [15:0] e);
    bit hs = 0;
    err_data = e; err_valid = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = err_ready;
      @(posedge clk); #1;
    end
    err_valid = 1'b0;
    check("err_handshake", {31'h0, hs}, 1);
  endtask

  task automatic wait_fbk();
    bit hs = 0;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = fbk_valid && fbk_ready;
      @(posedge clk); #1;
    end
    check("fbk_handshake", {31'h0, hs}, 1);
  endtask

  task automatic xact(input logic [15:0] a, input logic t, input logic [15:0] er,
                      input logic [15:0] e_res, input logic [31:0] e_fbk);
    res_q.push_back(e_res);
    if (t) fbk_q.push_back(e_fbk);
    send_arg(a, t);
    wait_res();
    if (t) begin
      send_err(er);
      wait_fbk();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arg_valid = 1'b0; err_valid = 1'b0; res_ready = 1'b1; fbk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_w[0] = 0; m_w[1] = 0; m_b = 0;
    res_q.delete(); fbk_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic train_run(input string name, input logic [3:0][15:0] tgts);
    for (int ep = 0; ep < 25; ep++) begin
      for (int p = 0; p < 4; p++) begin
        int r, act, er;
        logic [31:0] f;
        r   = m_fwd(pats[p]);
        act = (r >= 0) ? 255 : 0;
        er  = int'(tgts[p]) - act;
        f   = m_bwd(pats[p], er);
        xact(pats[p], 1'b1, 16'(er), 16'(r), f);
      end
    end
    for (int p = 0; p < 4; p++) begin
      int r;
      logic [15:0] act_dut;
      r = m_fwd(pats[p]);
      xact(pats[p], 1'b0, 16'h0, 16'(r), 32'h0);
      act_dut = ($signed(last_res) >= 0) ? 16'h00FF : 16'h0000;
      check({name, "_class"}, {16'h0, act_dut}, {16'h0, tgts[p]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit hs;
    pats  = {16'hFFFF, 16'hFF00, 16'h00FF, 16'h0000};
    rst_n = 1'b0; train = 1'b0; arg_valid = 1'b0; arg_data = '0; res_ready = 1'b1;
    err_valid = 1'b0; err_data = '0; fbk_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_arg_ready", {31'h0, arg_ready}, 0);
    check("rst_res_valid", {31'h0, res_valid}, 0);
    check("rst_err_ready", {31'h0, err_ready}, 0);
    check("rst_fbk_valid", {31'h0, fbk_valid}, 0);
    check("rst_res_data", {16'h0, res_data}, 0);
    check("rst_fbk_data", fbk_data, 0);
    do_reset();

    // Directed vectors: arg, train, err, expected res, expected {fbk1, fbk0}.
    xact(16'h0000, 1'b0, 16'h0000, 16'h0000, 32'h0);
    xact(16'h0000, 1'b1, 16'h0000, 16'h0000, 32'h0);
    xact(16'hFFFF, 1'b1, 16'h00FF, 16'h0000, 32'h0);          // w=254,254 b=255
    xact(16'hFFFF, 1'b0, 16'h0000, 16'h02F9, 32'h0);
    xact(16'h00FF, 1'b1, 16'h0100, 16'h01FC, 32'h00FE_00FE);  // w=509,254 b=511
    xact(16'hFF00, 1'b0, 16'h0000, 16'h02FC, 32'h0);
    xact(16'hFF00, 1'b1, 16'hFF00, 16'h02FC, 32'hFF02_FE03);  // w=509,-1 b=255
    xact(16'h0101, 1'b0, 16'h0000, 16'h00FF, 32'h0);

    // Backpressure on the result channel.
    res_q.push_back(16'h00FE);
    res_ready = 1'b0;
    send_arg(16'hFF00, 1'b0);
    hs = 0;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = res_valid;
    end
    check("bp_valid_seen", {31'h0, hs}, 1);
    repeat (5) begin
      check("bp_res_data", {16'h0, res_data}, 32'h00FE);
      check("bp_arg_ready", {31'h0, arg_ready}, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_res();

    // Reset in the middle of the backward pass.
    res_q.push_back(16'h02FA);
    send_arg(16'h00FF, 1'b1);
    wait_res();
    send_err(16'h0010);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_arg_ready", {31'h0, arg_ready}, 0);
    check("abort_res_valid", {31'h0, res_valid}, 0);
    check("abort_err_ready", {31'h0, err_ready}, 0);
    check("abort_fbk_valid", {31'h0, fbk_valid}, 0);
    check("abort_fbk_data", fbk_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_w[0] = 0; m_w[1] = 0; m_b = 0;
    res_q.delete(); fbk_q.delete();
    repeat (2) @(posedge clk);
    #1;
    xact(16'hFFFF, 1'b0, 16'h0000, 16'h0000, 32'h0);

    do_reset();
    train_run("and", {16'h00FF, 16'h0000, 16'h0000, 16'h0000});
    do_reset();
    train_run("or", {16'h00FF, 16'h00FF, 16'h00FF, 16'h0000});

    repeat (3) @(posedge clk);
    check("res_q_drained", res_q.size(), 0);
    check("fbk_q_drained", fbk_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/associate_unit.md
# associate_unit

Trainable single-neuron linear associator: it computes a Q8.8 weighted sum of N unsigned 8-bit arguments plus a bias. In training mode it accepts an error, returns per-input back-propagated feedback and applies a perceptron/LMS weight update. It sits as a leaf compute element in the learning datapath. Upstream and downstream blocks connect to it through valid/ready streams.

## Interface
- N, 2, number of arguments/weights
- RATE, 0, learning-rate right shift applied to weight/bias deltas
- SEED, 0, initial-weight seed; 0 means all weights and bias reset to zero, nonzero loads weights from a 16-bit LFSR seeded with SEED
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- train  in  1  1 = forward pass followed by backward pass; sampled when an argument is accepted
- arg_valid/arg_ready  in/out  1/1  argument handshake
- arg_data  in  [N][8]  unsigned Q0.8 arguments
- res_valid/res_ready  out/in  1/1  result handshake
- res_data  out  16  signed Q8.8 result
- err_valid/err_ready  in/out  1/1  error handshake
- err_data  in  16  signed Q8.8 error (target − actual)
- fbk_valid/fbk_ready  out/in  1/1  feedback handshake
- fbk_data  out  [N][16]  signed Q8.8 per-input feedback

## Operation
- States: ARG → FWD → RES → (train ? ERR → BWD → FBK : ARG) → ARG.
- ARG: arg_ready=1. The transfer latches arg_data and train.
- FWD: acc = bias + Σ (weight[i]·arg[i]) >>> 8. Each product is 24-bit signed, arithmetic-shifted. The accumulator is 20 bits, then reduced to 16 bits.
- RES: res_valid=1 with the result held stable until res_ready.
- ERR: err_ready=1. The transfer latches err_data.
- BWD: fbk[i] = (err·weight[i]) >>> 8, using pre-update weights. Then weight[i] += ((err·arg[i]) >>> 8) >>> RATE and bias += err >>> RATE, all 16-bit signed.
- FBK: fbk_valid=1 until fbk_ready.
- When train=0, an err_valid pulse is ignored (err_ready stays 0).
- Weights and bias persist across transactions and are cleared or re-seeded only by reset.

## Timing
- Reset values: arg_ready=0, res_valid=0, err_ready=0, fbk_valid=0, res_data=0, fbk_data=0, state=ARG. arg_ready rises the first cycle after reset deasserts.
- FWD takes N cycles (one multiply-accumulate per cycle). Result latency from the arg handshake to res_valid is N+1 cycles.
- BWD takes N+1 cycles (N weights, then bias). fbk_valid asserts N+2 cycles after the err handshake.
- Only one of arg_ready/res_valid/err_ready/fbk_valid is high at a time; there is no overlap or pipelining.
- Valid outputs and their data stay stable until the handshake completes.
- An asynchronous reset mid-transaction aborts it. Weights return to their seed values.

## Configuration
- ASSOCIATE_SATURATE_EN defined: the result and all updated weight/bias values saturate to 0x7FFF or 0x8000 on overflow.
- ASSOCIATE_SATURATE_EN undefined: these values wrap (two's complement truncation).

## Structure
- Package associate_pkg: arg_t (8-bit unsigned), fix_t (16-bit signed Q8.8), state enum (ARG, FWD, RES, ERR, BWD, FBK), and a sat16 function.
- Sub-module associate_mul: signed fixed-point multiply with a >>>8 shift. It is shared by the forward MAC, the feedback and the weight-delta computations.

## Test plan
- After reset with SEED=0, train=0, arg=0x0000 -> res=0x0000.
- train=1, arg=0x0000 -> res=0x0000. Then err=0x0000 -> fbk=0x0000_0000, weights unchanged.
- Training case, starting from zero weights: arg=0xFFFF, train=1 -> res=0x0000. Then err=0x00FF -> fbk=0. The next forward with arg=0xFFFF yields res>0.
- AND training: 25 epochs over args {0000, 00FF, FF00, FFFF} with targets {0, 0, 0, 00FF}. Actual = 00FF if res≥0, else 0. Afterwards, with train=0, all four errors are 0.
- OR training: same procedure after reset with targets {0, 00FF, 00FF, 00FF} -> all errors 0.
- Backpressure: hold res_ready=0 for 5 cycles -> res_data is stable and arg_ready stays 0. An assertion of reset mid-BWD -> all valids and readies are 0 and weights are zeroed.
